// File: rtl/ir_pkg.sv
// Shared types and helpers for the instruction assembly register.
// Provides the FILL/HOLD state type, the beat-to-lane mapping and the
// width sanity check used at elaboration by the top module.
package ir_pkg;

  typedef enum logic [0:0] {
    FILL = 1'b0,
    HOLD = 1'b1
  } ir_state_t;

  // Lane that beat number 'beat' lands in; MSB-first mirrors the order.
  function automatic int ir_lane(input int beat, input int nb, input bit msb_first);
    if (msb_first) begin
      return nb - 1 - beat;
    end else begin
      return beat;
    end
  endfunction

  // Instruction must be a whole number (at least two) of beats.
  function automatic bit ir_width_ok(input int iw, input int bw);
    return (bw > 0) && ((iw % bw) == 0) && ((iw / bw) >= 2);
  endfunction

endpackage

// File: rtl/ir_assembly_buffer.sv
// Holding buffer for the first NB-1 beats of an instruction while the
// previous instruction is still waiting in the output register. Beats are
// stored in arrival order; lane mirroring happens when the word is composed.
module ir_assembly_buffer #(
  parameter int BW = 8,
  parameter int NB = 2,
  parameter int CW = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   we,
  input  logic [CW-1:0]          idx,
  input  logic [BW-1:0]          d,
  output logic [(NB-1)*BW-1:0]   beats
);

  // Capture one beat at its arrival slot; clear drops any partial word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beats <= '0;
    end else if (clr) begin
      beats <= '0;
    end else if (we && (int'(idx) < NB - 1)) begin
      beats[int'(idx)*BW +: BW] <= d;
    end else begin
      beats <= beats;
    end
  end

endmodule

// File: rtl/instruction_assembly_register.sv
// Instruction register assembling an IW-bit word from NB successive BW-bit
// beats, with valid/ready on both sides and a flush for control-flow changes.
// Optional feature macro: IR_SKID_EN -- adds an (NB-1)-beat assembly buffer
// so the next instruction can fill while the current one is held, giving one
// instruction per NB cycles instead of NB+1.
module instruction_assembly_register
  import ir_pkg::*;
#(
  parameter  int IW        = 16,
  parameter  int BW        = 8,
  parameter  int MSB_FIRST = 0,
  localparam int NB        = IW / BW,
  localparam int CW        = $clog2(NB + 1)
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic [BW-1:0] I,
  input  logic          InValid,
  output logic          InReady,
  input  logic          Flush,
  output logic [IW-1:0] IROut,
  output logic          OutValid,
  input  logic          OutReady,
  output logic [CW-1:0] BeatCount
);

  if (!ir_width_ok(IW, BW)) begin : g_bad_width
    $error("instruction_assembly_register: IW must be a multiple (>=2) of BW");
  end

  localparam logic [CW-1:0] LAST_IDX = CW'(NB - 1);
  localparam bit            MIRROR   = (MSB_FIRST != 0);

  ir_state_t     state;
  ir_state_t     state_next;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic [IW-1:0] ir_next;
  logic          last;
  logic          accept;
  logic          complete;
  logic          consume;
  logic          load;

  assign OutValid  = (state == HOLD);
  assign BeatCount = count;
  assign last      = (count == LAST_IDX);
  assign consume   = OutValid && OutReady;
  assign accept    = InValid && InReady && !Flush;
  assign complete  = accept && last;

`ifdef IR_SKID_EN
  logic [(NB-1)*BW-1:0] beats;

  // Only a held word that will not be consumed blocks the final beat.
  assign InReady = !(OutValid && !OutReady && last);
  assign load    = complete;

  ir_assembly_buffer #(
    .BW(BW),
    .NB(NB),
    .CW(CW)
  ) u_buf (
    .clk  (Clock),
    .rst  (Reset),
    .clr  (Flush),
    .we   (accept && !last),
    .idx  (count),
    .d    (I),
    .beats(beats)
  );

  // Full word from buffered beats plus the final beat written straight through.
  always_comb begin
    ir_next = '0;
    for (int k = 0; k < NB - 1; k++) begin
      ir_next[ir_lane(k, NB, MIRROR)*BW +: BW] = beats[k*BW +: BW];
    end
    ir_next[ir_lane(NB - 1, NB, MIRROR)*BW +: BW] = I;
  end
`else
  // No buffering: the output register is the assembly area.
  assign InReady = !OutValid;
  assign load    = accept;

  // Replace only the lane addressed by the current beat.
  always_comb begin
    ir_next = IROut;
    ir_next[ir_lane(int'(count), NB, MIRROR)*BW +: BW] = I;
  end
`endif

  // Next-state and beat counter; flush overrides beats and consumption.
  always_comb begin
    state_next = state;
    count_next = count;
    if (Flush) begin
      state_next = FILL;
      count_next = '0;
    end else begin
      if (accept) begin
        count_next = last ? '0 : (count + CW'(1));
      end else begin
        count_next = count;
      end
      case (state)
        FILL: begin
          if (complete) begin
            state_next = HOLD;
          end else begin
            state_next = FILL;
          end
        end
        HOLD: begin
          if (complete) begin
            state_next = HOLD;
          end else if (consume) begin
            state_next = FILL;
          end else begin
            state_next = HOLD;
          end
        end
        default: state_next = FILL;
      endcase
    end
  end

  // State, counter and output register with asynchronous reset.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state <= FILL;
      count <= '0;
      IROut <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
      if (load) begin
        IROut <= ir_next;
      end
    end
  end

endmodule
